// File: rtl/i2s_transmitter.sv
// ---------------------------------------------------------------------------
// i2s_transmitter
//
// Buffers 16-bit PCM samples from the tone generator in a small FIFO and
// serialises each one as a stereo I2S frame with the same word on both
// channels. The bit clock and word select are divided down from clk. All
// outputs are registered and change only on the clk cycle of a bclk
// falling edge, so the codec can sample cleanly on the rising edge.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   sample[15:0]   in   signed PCM sample from the tone generator
//   sample_valid   in   sample is presented this cycle
//   sink_ready     out  FIFO can accept a sample this cycle
//   bclk           out  I2S bit clock (32 bclk per frame)
//   lrclk          out  I2S word select, 0 = left, 1 = right
//   sdata          out  I2S serial data, MSB first, one-bit delayed
//   underrun       out  one-clk pulse when a frame starts with the FIFO empty
//   underrun_count out  saturating count of underruns
// ---------------------------------------------------------------------------
module i2s_transmitter #(
   parameter int unsigned BCLK_HALF  = 16,  // clk cycles per bclk half-period, >= 2
   parameter int unsigned FIFO_DEPTH = 4    // power of two, >= 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] sample,
   input  logic        sample_valid,
   output logic        sink_ready,
   output logic        bclk,
   output logic        lrclk,
   output logic        sdata,
   output logic        underrun,
   output logic [15:0] underrun_count
);

   localparam int unsigned DIV_W = $clog2(BCLK_HALF);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [DIV_W-1:0] div_reg;
   logic             bclk_reg;
   logic [4:0]       slot_reg;
   logic             lrclk_reg;
   logic             sdata_reg;
   logic [15:0]      tx_word_reg;
   logic             underrun_reg;
   logic [15:0]      underrun_count_reg;

   logic [15:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [OCC_W-1:0] occ_reg;

   // ------------------------------------------------------------------
   // Combinational decode
   // ------------------------------------------------------------------
   logic       div_terminal;
   logic       fall_event;
   logic       frame_start;
   logic [4:0] slot_next;
   logic [3:0] bit_idx;
   logic       sdata_next;
   logic       fifo_empty;
   logic       fifo_full;
   logic       push;
   logic       pop;

   assign div_terminal = (div_reg == DIV_W'(BCLK_HALF - 1));
   assign fall_event   = div_terminal && bclk_reg;
   assign slot_next    = slot_reg + 5'd1;
   // Entering slot 0 is the frame boundary: that is where the FIFO is popped.
   assign frame_start  = fall_event && (slot_next == 5'd0);

   assign fifo_empty = (occ_reg == OCC_W'(0));
   assign fifo_full  = (occ_reg == OCC_W'(FIFO_DEPTH));

   // Ready depends only on registered occupancy; a slot freed by a pop
   // becomes visible on the following cycle.
   assign sink_ready = !reset && !fifo_full;
   assign push       = sample_valid && sink_ready;
   assign pop        = frame_start && !fifo_empty;

   // With the one-bit I2S delay, slots 1..16 carry bits 15..0 and slots
   // 17..31 carry bits 15..1, then slot 0 carries bit 0. In every case the
   // bit index is (-slot) mod 16. At slot 0 tx_word_reg still holds the
   // previous frame's word, because the newly popped word lands on the
   // same edge.
   always_comb begin
      bit_idx    = 4'(5'd0 - slot_next);
      sdata_next = tx_word_reg[bit_idx];
   end

   // ------------------------------------------------------------------
   // FIFO storage: no reset, only the pointers are cleared.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= sample;
      end
   end

   // ------------------------------------------------------------------
   // Clock divider, frame slot counter, serialiser and FIFO control
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_reg            <= '0;
         bclk_reg           <= 1'b0;
         slot_reg           <= 5'd31;
         lrclk_reg          <= 1'b1;
         sdata_reg          <= 1'b0;
         tx_word_reg        <= 16'h0000;
         underrun_reg       <= 1'b0;
         underrun_count_reg <= 16'h0000;
         wr_ptr_reg         <= '0;
         rd_ptr_reg         <= '0;
         occ_reg            <= '0;
      end else begin
         // Divider and bit clock
         if (div_terminal) begin
            div_reg  <= '0;
            bclk_reg <= !bclk_reg;
         end else begin
            div_reg <= div_reg + DIV_W'(1);
         end

         underrun_reg <= 1'b0;

         // Frame outputs move only on bclk falling edges
         if (fall_event) begin
            slot_reg  <= slot_next;
            lrclk_reg <= slot_next[4];
            sdata_reg <= sdata_next;
            if (frame_start) begin
               if (fifo_empty) begin
                  tx_word_reg  <= 16'h0000;
                  underrun_reg <= 1'b1;
                  if (underrun_count_reg != 16'hFFFF) begin
                     underrun_count_reg <= underrun_count_reg + 16'd1;
                  end
               end else begin
                  tx_word_reg <= fifo_mem[rd_ptr_reg];
               end
            end
         end

         // FIFO pointers and occupancy
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   occ_reg <= occ_reg + OCC_W'(1);
            2'b01:   occ_reg <= occ_reg - OCC_W'(1);
            default: occ_reg <= occ_reg;
         endcase
      end
   end

   assign bclk           = bclk_reg;
   assign lrclk          = lrclk_reg;
   assign sdata          = sdata_reg;
   assign underrun       = underrun_reg;
   assign underrun_count = underrun_count_reg;

endmodule

// File: tb/tb_i2s_transmitter.sv
// ---------------------------------------------------------------------------
// tb_i2s_transmitter
//
// Self-checking bench for i2s_transmitter at default parameters. A
// frame-level model (sample queue, per-frame word record, outputs derived
// from the clk count since reset release) is compared against the DUT on
// every falling clk edge. Directed scenarios add hand-computed literal
// expectations on timing, captured serial bits and counters.
// ---------------------------------------------------------------------------
module tb_i2s_transmitter;

   localparam int BCLK_HALF  = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int FRAME_CLK  = 64 * BCLK_HALF;
   localparam int SLOT_CLK   = 2 * BCLK_HALF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] sample = 16'h0000;
   logic        sample_valid = 1'b0;
   logic        sink_ready;
   logic        bclk;
   logic        lrclk;
   logic        sdata;
   logic        underrun;
   logic [15:0] underrun_count;

   i2s_transmitter #(
      .BCLK_HALF  (BCLK_HALF),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .sample         (sample),
      .sample_valid   (sample_valid),
      .sink_ready     (sink_ready),
      .bclk           (bclk),
      .lrclk          (lrclk),
      .sdata          (sdata),
      .underrun       (underrun),
      .underrun_count (underrun_count)
   );

   always #5 clk = ~clk;

   int pass_count = 0;
   int total_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_count++;
      if (act === exp) pass_count++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ------------------------------------------------------------------
   // Frame-level model
   // ------------------------------------------------------------------
   int          m_k = 0;              // clk edges since reset release
   logic [15:0] m_q[$];
   logic [15:0] m_cur_word = 16'h0000;
   logic [15:0] m_prev_word = 16'h0000;
   logic        m_underrun = 1'b0;
   logic [15:0] m_count = 16'h0000;
   logic [15:0] m_frame_word [0:63];

   function automatic int slot_of(input int k);
      if (k < SLOT_CLK) return 31;
      return ((k - SLOT_CLK) / SLOT_CLK) % 32;
   endfunction

   function automatic logic exp_bclk(input int k);
      return ((k / BCLK_HALF) % 2) == 1;
   endfunction

   function automatic logic exp_sdata(input int k);
      int s;
      if (k < SLOT_CLK) return 1'b0;
      s = slot_of(k);
      if (s == 0)       return m_prev_word[0];
      else if (s <= 16) return m_cur_word[16 - s];
      else              return m_cur_word[32 - s];
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_k = 0;
            m_q.delete();
            m_cur_word = 16'h0000;
            m_prev_word = 16'h0000;
            m_underrun = 1'b0;
            m_count = 16'h0000;
         end else begin
            logic ready_before;
            ready_before = (m_q.size() < FIFO_DEPTH);
            m_k++;
            m_underrun = 1'b0;
            if (m_k >= SLOT_CLK && ((m_k - SLOT_CLK) % FRAME_CLK) == 0) begin
               int f;
               f = (m_k - SLOT_CLK) / FRAME_CLK;
               m_prev_word = m_cur_word;
               if (m_q.size() == 0) begin
                  m_cur_word = 16'h0000;
                  m_underrun = 1'b1;
                  if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
               end else begin
                  m_cur_word = m_q.pop_front();
               end
               if (f < 64) m_frame_word[f] = m_cur_word;
            end
            if (sample_valid && ready_before) m_q.push_back(sample);
         end
      end
   end

   // Every-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         check("bclk",           bclk,           reset ? 1'b0 : exp_bclk(m_k));
         check("lrclk",          lrclk,          reset ? 1'b1 : (slot_of(m_k) >= 16));
         check("sdata",          sdata,          reset ? 1'b0 : exp_sdata(m_k));
         check("underrun",       underrun,       reset ? 1'b0 : m_underrun);
         check("underrun_count", underrun_count, m_count);
         check("sink_ready",     sink_ready,     !reset && (m_q.size() < FIFO_DEPTH));
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
   endtask

   // Literal timing expectations right after reset release with no input
   task automatic check_startup(input string tag);
      for (int i = 1; i <= 600; i++) begin
         @(negedge clk);
         if (i == 15)  check({tag, ".bclk_low15"},   bclk, 1'b0);
         if (i == 16)  check({tag, ".bclk_rise16"},  bclk, 1'b1);
         if (i == 31)  check({tag, ".bclk_high31"},  bclk, 1'b1);
         if (i == 32)  check({tag, ".bclk_fall32"},  bclk, 1'b0);
         if (i == 48)  check({tag, ".bclk_rise48"},  bclk, 1'b1);
         if (i == 31)  check({tag, ".lrclk31"},      lrclk, 1'b1);
         if (i == 32)  check({tag, ".lrclk32"},      lrclk, 1'b0);
         if (i == 543) check({tag, ".lrclk543"},     lrclk, 1'b0);
         if (i == 544) check({tag, ".lrclk544"},     lrclk, 1'b1);
         if (i == 31)  check({tag, ".underrun31"},   underrun, 1'b0);
         if (i == 32)  check({tag, ".underrun32"},   underrun, 1'b1);
         if (i == 33)  check({tag, ".underrun33"},   underrun, 1'b0);
         if (i == 600) check({tag, ".count"},        underrun_count, 16'd1);
      end
   endtask

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   initial begin
      logic [32:0] bits;
      logic [32:0] bits_exp;
      logic        rdy_prev;
      int          accepts;
      int          first_drop;
      int          ready_highs;
      int          pulses;

      // 1: reset release, no input
      $display("scenario 1: idle start-up");
      do_reset();
      check_startup("idle");

      // 2: single word 0xA5C3, capture on bclk rising edges
      do_reset();
      sample_valid = 1'b1;
      sample = 16'hA5C3;
      @(negedge clk);
      sample_valid = 1'b0;
      $display("push 0xa5c3");
      @(posedge bclk);                      // slot 31 before the first frame
      bits = '0;
      repeat (33) begin
         @(posedge bclk);
         #1 bits = {bits[31:0], sdata};
      end
      bits_exp = {1'b0, 16'hA5C3, 15'h52E1, 1'b1};
      check("a5c3.serial", bits, bits_exp);
      check("a5c3.model_frame0", m_frame_word[0], 16'hA5C3);
      check("a5c3.count", underrun_count, 16'd1);  // only the empty second frame

      // 3: continuous source with incrementing data
      do_reset();
      accepts = 0;
      first_drop = -1;
      ready_highs = 0;
      sample_valid = 1'b1;
      sample = 16'd0;
      #1 rdy_prev = sink_ready;
      for (int i = 1; i <= 5200; i++) begin
         @(negedge clk);
         if (rdy_prev) begin
            $display("accept %0d sample=0x%04h", accepts, 16'(accepts));
            accepts++;
            sample = 16'(accepts);
         end
         rdy_prev = sink_ready;
         if (first_drop < 0 && !sink_ready) first_drop = accepts;
         else if (first_drop >= 0 && sink_ready) ready_highs++;
      end
      sample_valid = 1'b0;
      check("stream.first_drop_accepts", first_drop, 4);
      check("stream.ready_pulses", ready_highs, 6);
      for (int f = 0; f < 6; f++) check("stream.frame_word", m_frame_word[f], 16'(f));
      check("stream.count", underrun_count, 16'd0);

      // 4: two samples, three starved frames, then one more sample
      do_reset();
      pulses = 0;
      sample_valid = 1'b1;
      sample = 16'h1111;
      for (int i = 1; i <= 5200; i++) begin
         @(negedge clk);
         if (i == 1) sample = 16'h2222;
         if (i == 2) sample_valid = 1'b0;
         if (i == 4200) begin
            sample_valid = 1'b1;
            sample = 16'h3333;
            $display("push 0x3333");
         end
         if (i == 4201) sample_valid = 1'b0;
         if (underrun) pulses++;
      end
      check("starve.pulses", pulses, 3);
      check("starve.count", underrun_count, 16'd3);
      check("starve.frame0", m_frame_word[0], 16'h1111);
      check("starve.frame1", m_frame_word[1], 16'h2222);
      check("starve.frame2", m_frame_word[2], 16'h0000);
      check("starve.frame4", m_frame_word[4], 16'h0000);
      check("starve.frame5", m_frame_word[5], 16'h3333);

      // 5: saturation of underrun_count
      do_reset();
      pulses = 0;
      for (int i = 1; i <= 2100; i++) begin
         @(negedge clk);
         if (i == 100) begin
            #1 force dut.underrun_count_reg = 16'hFFFE;
            #1 release dut.underrun_count_reg;
            m_count = 16'hFFFE;
            $display("preset underrun_count 0xfffe");
         end
         if (i > 100 && underrun) pulses++;
         if (i == 1100) check("sat.count_ffff", underrun_count, 16'hFFFF);
      end
      check("sat.count_held", underrun_count, 16'hFFFF);
      check("sat.pulses", pulses, 2);

      // 6: reset during slot 9 with three samples queued
      do_reset();
      sample_valid = 1'b1;
      sample = 16'hB000;
      for (int i = 1; i <= 330; i++) begin
         @(negedge clk);
         if (i <= 3) sample = 16'hB000 + 16'(i);
         if (i == 4) sample_valid = 1'b0;
      end
      check("midreset.frame0", m_frame_word[0], 16'hB000);
      #2 reset = 1'b1;
      #1;
      check("midreset.bclk",     bclk, 1'b0);
      check("midreset.lrclk",    lrclk, 1'b1);
      check("midreset.sdata",    sdata, 1'b0);
      check("midreset.underrun", underrun, 1'b0);
      check("midreset.count",    underrun_count, 16'd0);
      check("midreset.ready",    sink_ready, 1'b0);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      check_startup("after_reset");

      $display("%0d/%0d checks passed", pass_count, total_count);
      $finish;
   end

endmodule
